level_sequencer: RTL
====================

LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 Parameter NOTE_TICKS, default 25000000, clk cycles a note is lit during playback (>=1).
REQ-002 Parameter GAP_TICKS, default 12500000, dark cycles after each played note (>=1).
REQ-003 Parameter TIMEOUT_TICKS, default 150000000, cycles allowed per player key before loss (>=1).
REQ-004 Parameter MAX_LEN, default 8, sequence length that wins the game (1..8).
REQ-005 Parameter SEED, default 8'hA5, LFSR reset value; 0 SHALL be replaced by 8'h01.
REQ-006 clk  input  1  single clock; all state changes on posedge clk.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  single-cycle pulse; begins a new game.
REQ-009 key_valid  input  1  single-cycle pulse; one player key press, debounced and edge-detected upstream.
REQ-010 key_code  input  4  pressed key, one-hot; sampled only with key_valid.
REQ-011 note_out  output  4  one-hot note lit during playback, else 0.
REQ-012 state_out  output  4  current state code for 7-segment display.
REQ-013 level_len  output  4  current sequence length, 0..MAX_LEN.
REQ-014 won  output  1  high while in WON.
REQ-015 lost  output  1  high while in LOST.

Function
REQ-016 States/codes: IDLE=0, EXTEND=1, PLAY_ON=2, PLAY_OFF=3, WAIT_KEY=4, WON=5, LOST=6; state_out SHALL equal the code.
REQ-017 Internal storage: 8 slots x 2-bit note index, sequence index idx (3 bits), 32-bit down-timer, 8-bit LFSR.
REQ-018 LFSR: Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifts every cycle in every state except during reset; new note = lfsr[1:0].
REQ-019 IDLE/WON/LOST + start: level_len<=0, idx<=0, next state EXTEND; start ignored in all other states.
REQ-020 EXTEND (exactly 1 cycle): slot[level_len]<=lfsr[1:0], level_len<=level_len+1, idx<=0, timer<=NOTE_TICKS-1, next PLAY_ON; earlier slots unchanged.
REQ-021 PLAY_ON: note_out = one-hot(slot[idx]) (index n -> bit n); timer decrements; at timer==0 -> PLAY_OFF, timer<=GAP_TICKS-1.
REQ-022 PLAY_OFF: note_out=0; at timer==0: if idx==level_len-1 -> WAIT_KEY, idx<=0, timer<=TIMEOUT_TICKS-1; else idx<=idx+1, timer<=NOTE_TICKS-1, PLAY_ON.
REQ-023 Each played note SHALL occupy exactly NOTE_TICKS lit plus GAP_TICKS dark cycles; playback of length L lasts L*(NOTE_TICKS+GAP_TICKS) cycles.
REQ-024 WAIT_KEY, key_valid with key_code == one-hot(slot[idx]): if idx<level_len-1 -> idx<=idx+1, timer<=TIMEOUT_TICKS-1, stay; else if level_len==MAX_LEN -> WON; else -> EXTEND.
REQ-025 WAIT_KEY, key_valid with any other key_code (including 0 and multi-hot) -> LOST next cycle.
REQ-026 WAIT_KEY, no key_valid, timer==0 -> LOST; key_valid in the timer==0 cycle SHALL be evaluated per REQ-024/025 instead.
REQ-027 key_valid outside WAIT_KEY SHALL be ignored with no state change.
REQ-028 WON and LOST hold until start or reset; note_out=0; level_len holds final value.
REQ-029 All outputs SHALL be decoded from registers only; no combinational path from any input to any output.

Reset
REQ-030 reset SHALL force state IDLE, level_len 0, idx 0, timer 0, LFSR SEED, note_out 0, won 0, lost 0 on the next edge, from any state, including mid-playback and mid-response.
REQ-031 reset SHALL take priority over start and key_valid in the same cycle; slot contents need not be cleared.

Verification (NOTE_TICKS=2, GAP_TICKS=1, TIMEOUT_TICKS=5, MAX_LEN=2, SEED=8'hA5)
REQ-032 reset, start pulse -> EXTEND 1 cycle, level_len=1; PLAY_ON 2 cycles with note_out=one-hot(model LFSR[1:0]); PLAY_OFF 1 cycle note_out=0; then state_out=4.
REQ-033 Correct keys each round -> round 2 replays slot0 then new slot1 (6 playback cycles); correct 2-key response -> won=1, state_out=5, level_len=2.
REQ-034 In WAIT_KEY, key_code mismatching expected (also 4'b0011) -> next cycle lost=1, state_out=6, note_out=0; later start -> EXTEND, level_len=1.
REQ-035 No key for 5 WAIT_KEY cycles -> LOST; repeat with correct key_valid in the 5th cycle -> accepted, no loss.
REQ-036 reset asserted in PLAY_ON together with start -> next cycle state_out=0, note_out=0, level_len=0, won=lost=0.
REQ-037 key_valid pulses during PLAY_ON/PLAY_OFF -> playback timing and state sequence unchanged versus run without them.

Source files
------------

// File: rtl/level_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : level_sequencer
// Description : Memory game sequencer. Each round appends a pseudo-random note
//               to the stored sequence, plays it back on note_out, then checks
//               the player's key presses against it. The player wins at
//               MAX_LEN notes and loses on a wrong key or on a key timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module level_sequencer #(
  parameter int          NOTE_TICKS    = 25000000,
  parameter int          GAP_TICKS     = 12500000,
  parameter int          TIMEOUT_TICKS = 150000000,
  parameter int          MAX_LEN       = 8,
  parameter logic [7:0]  SEED          = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] note_out,
  output logic [3:0] state_out,
  output logic [3:0] level_len,
  output logic       won,
  output logic       lost
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_EXTEND   = 3'd1;
  localparam logic [2:0] S_PLAY_ON  = 3'd2;
  localparam logic [2:0] S_PLAY_OFF = 3'd3;
  localparam logic [2:0] S_WAIT_KEY = 3'd4;
  localparam logic [2:0] S_WON      = 3'd5;
  localparam logic [2:0] S_LOST     = 3'd6;

  // An all-zero seed would lock the LFSR up, so it is replaced by 1.
  localparam logic [7:0]  C_SEED        = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [31:0] C_NOTE_RELOAD = 32'(NOTE_TICKS - 1);
  localparam logic [31:0] C_GAP_RELOAD  = 32'(GAP_TICKS - 1);
  localparam logic [31:0] C_TMO_RELOAD  = 32'(TIMEOUT_TICKS - 1);
  localparam logic [3:0]  C_MAX_LEN     = 4'(MAX_LEN);

  logic [2:0]  r_state;
  logic [3:0]  r_level_len;
  logic [2:0]  r_idx;
  logic [31:0] r_timer;
  logic [7:0]  r_lfsr;
  logic [1:0]  r_slot [8];

  logic        w_lfsr_fb;
  logic [1:0]  w_cur_note;
  logic [3:0]  w_cur_onehot;
  logic        w_last_idx;
  logic        w_timer_zero;

  // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting Fibonacci register.
  assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_cur_note   = r_slot[r_idx];
  assign w_cur_onehot = 4'b0001 << w_cur_note;
  assign w_last_idx   = ({1'b0, r_idx} == (r_level_len - 4'd1));
  assign w_timer_zero = (r_timer == 32'd0);

  // Outputs are pure decodes of registered state.
  assign state_out = {1'b0, r_state};
  assign note_out  = (r_state == S_PLAY_ON) ? w_cur_onehot : 4'b0000;
  assign level_len = r_level_len;
  assign won       = (r_state == S_WON);
  assign lost      = (r_state == S_LOST);

  // Free-running LFSR; reset reloads the seed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= C_SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end

  // Sequence storage; only appended to in EXTEND, never cleared.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == S_EXTEND)) begin
      r_slot[r_level_len[2:0]] <= r_lfsr[1:0];
    end
  end

  // Game state machine with shared down-timer for note, gap and key timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_level_len <= 4'd0;
      r_idx       <= 3'd0;
      r_timer     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE, S_WON, S_LOST: begin
          if (start) begin
            r_level_len <= 4'd0;
            r_idx       <= 3'd0;
            r_state     <= S_EXTEND;
          end
        end

        S_EXTEND: begin
          r_level_len <= r_level_len + 4'd1;
          r_idx       <= 3'd0;
          r_timer     <= C_NOTE_RELOAD;
          r_state     <= S_PLAY_ON;
        end

        S_PLAY_ON: begin
          if (w_timer_zero) begin
            r_timer <= C_GAP_RELOAD;
            r_state <= S_PLAY_OFF;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end

        S_PLAY_OFF: begin
          if (w_timer_zero) begin
            if (w_last_idx) begin
              r_idx   <= 3'd0;
              r_timer <= C_TMO_RELOAD;
              r_state <= S_WAIT_KEY;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_timer <= C_NOTE_RELOAD;
              r_state <= S_PLAY_ON;
            end
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end

        S_WAIT_KEY: begin
          // A key press takes precedence over an expiring timeout.
          if (key_valid) begin
            if (key_code == w_cur_onehot) begin
              if (!w_last_idx) begin
                r_idx   <= r_idx + 3'd1;
                r_timer <= C_TMO_RELOAD;
              end else if (r_level_len == C_MAX_LEN) begin
                r_state <= S_WON;
              end else begin
                r_state <= S_EXTEND;
              end
            end else begin
              r_state <= S_LOST;
            end
          end else if (w_timer_zero) begin
            r_state <= S_LOST;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
